// File: rtl/synch_pkg.sv
`default_nettype none
// ============================================================================
// synch_pkg : shared types and constants for the cross-domain handshake blocks
// Revision  : 1.0
// ============================================================================
package synch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int XFER_W          = 8;

endpackage
`default_nettype wire

// File: rtl/synch_chain.sv
`default_nettype none
// ============================================================================
// synch_chain : N-stage flop synchroniser for a single level, async reset
// Revision    : 1.0
// ============================================================================
module synch_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/synch_resp.sv
`default_nettype none
// ============================================================================
// synch_resp : four-phase req/ack responder with one-entry valid/ready buffer
// Revision   : 1.0
// ============================================================================
module synch_resp
    import synch_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [WIDTH-1:0]  din,
    output logic              ack,
    output logic [WIDTH-1:0]  dout,
    output logic              dvalid,
    input  logic              dready,
    output logic [XFER_W-1:0] xfers
);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_param_check
            $error("synch_resp: SYNC_STAGES must be at least SYNC_STAGES_MIN");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_req_s;
    logic              w_free;
    logic              w_capture;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dvalid;
    logic [XFER_W-1:0] r_xfers;

    synch_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req),
        .q     (w_req_s)
    );

    // din is deliberately unsynchronised: the handshake holds it stable until ack is seen.
    assign w_free = !r_dvalid || dready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_s && w_free) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!w_req_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A capture on the same edge as a consume refills the buffer without a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_xfers  <= '0;
        end else if (w_capture) begin
            r_dout   <= din;
            r_dvalid <= 1'b1;
            r_xfers  <= r_xfers + {{(XFER_W-1){1'b0}}, 1'b1};
        end else if (r_dvalid && dready) begin
            r_dvalid <= 1'b0;
        end
    end

    assign ack    = (r_state == HOLD);
    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign xfers  = r_xfers;

endmodule
`default_nettype wire

// File: tb/tb_synch_resp.sv
`default_nettype none
// ============================================================================
// tb_synch_resp : directed scoreboard bench for synch_resp (depths 2 and 3)
// Revision      : 1.0
// ============================================================================
module tb_synch_resp;

    logic        clk;
    logic        reset;
    logic        req;
    logic        req3;
    logic [15:0] din;
    logic        dready;
    logic        ack,    ack3;
    logic [15:0] dout,   dout3;
    logic        dvalid, dvalid3;
    logic [7:0]  xfers,  xfers3;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_pushed = 0;
    int          n_popped = 0;
    logic [15:0] sb[$];

    synch_resp #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .xfers  (xfers)
    );

    synch_resp #(.WIDTH(16), .SYNC_STAGES(3)) dut3 (
        .clk    (clk),
        .reset  (reset),
        .req    (req3),
        .din    (din),
        .ack    (ack3),
        .dout   (dout3),
        .dvalid (dvalid3),
        .dready (dready),
        .xfers  (xfers3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        sb.push_back(w);
        n_pushed++;
    endtask

    task automatic wait_ack(input logic val, input string name);
        for (int k = 0; k < 20; k++) begin
            if (ack == val) break;
            tick(1);
        end
        check(name, {31'd0, ack}, {31'd0, val});
    endtask

    // Monitor: a word leaves the buffer on every edge with dvalid & dready.
    always @(negedge clk) begin
        if (!reset && dvalid && dready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {16'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {16'd0, dout}, {16'd0, sb.pop_front()});
                n_popped++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        req3   = 1'b0;
        din    = 16'h0000;
        dready = 1'b0;
        tick(2);
        check("rst_ack",    {31'd0, ack},    0);
        check("rst_dvalid", {31'd0, dvalid}, 0);
        check("rst_dout",   {16'd0, dout},   0);
        check("rst_xfers",  {24'd0, xfers},  0);
        reset = 1'b0;
        tick(1);

        // Single transfer
        din = 16'hA5C3; dready = 1'b1; req = 1'b1; push(16'hA5C3);
        tick(2);
        check("single_ack_e1", {31'd0, ack}, 0);
        tick(1);
        check("single_ack_e2",    {31'd0, ack},    1);
        check("single_dvalid_e2", {31'd0, dvalid}, 1);
        check("single_dout_e2",   {16'd0, dout},   32'hA5C3);
        tick(1);
        check("single_dvalid_e3", {31'd0, dvalid}, 0);
        req = 1'b0;
        tick(2);
        check("release_ack_e1", {31'd0, ack}, 1);
        tick(1);
        check("release_ack_e2", {31'd0, ack}, 0);
        check("single_xfers",   {24'd0, xfers}, 1);

        // Asynchronous reset, no clock edge
        reset = 1'b1;
        #1;
        check("async_rst_ack",    {31'd0, ack},    0);
        check("async_rst_dvalid", {31'd0, dvalid}, 0);
        check("async_rst_dout",   {16'd0, dout},   0);
        check("async_rst_xfers",  {24'd0, xfers},  0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Backpressure
        dready = 1'b0; din = 16'h0BAD; req = 1'b1; push(16'h0BAD);
        tick(3);
        check("bp_first_ack",  {31'd0, ack},  1);
        check("bp_first_dout", {16'd0, dout}, 32'h0BAD);
        req = 1'b0;
        tick(3);
        check("bp_first_release", {31'd0, ack},    0);
        check("bp_held_dvalid",   {31'd0, dvalid}, 1);
        din = 16'h1234; req = 1'b1; push(16'h1234);
        tick(5);
        check("bp_ack_low",  {31'd0, ack},   0);
        check("bp_dout_old", {16'd0, dout},  32'h0BAD);
        check("bp_xfers",    {24'd0, xfers}, 1);
        dready = 1'b1;
        tick(1);
        check("bp_cap_ack",    {31'd0, ack},    1);
        check("bp_cap_dout",   {16'd0, dout},   32'h1234);
        check("bp_cap_dvalid", {31'd0, dvalid}, 1);
        check("bp_cap_xfers",  {24'd0, xfers},  2);
        tick(1);
        check("bp_drain_dvalid", {31'd0, dvalid}, 0);
        req = 1'b0;
        wait_ack(1'b0, "bp_release");

        // Wrap: 256 transfers from a clean counter
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 256; i++) begin
            din = 16'(i * 16'h0101) ^ 16'h5A5A;
            push(din);
            req = 1'b1;
            wait_ack(1'b1, "wrap_ack_rise");
            req = 1'b0;
            wait_ack(1'b0, "wrap_ack_fall");
            if (i == 254) check("wrap_xfers_255", {24'd0, xfers}, 255);
        end
        tick(2);
        check("wrap_xfers_0", {24'd0, xfers}, 0);

        // Reset while holding, req stays high
        dready = 1'b0; din = 16'hBEEF; req = 1'b1;
        tick(3);
        check("hold_ack", {31'd0, ack}, 1);
        reset = 1'b1;
        #1;
        check("hold_rst_ack",    {31'd0, ack},    0);
        check("hold_rst_dvalid", {31'd0, dvalid}, 0);
        din = 16'hC0DE;
        tick(1);
        reset = 1'b0;
        push(16'hC0DE);
        tick(2);
        check("post_rst_ack_e1", {31'd0, ack}, 0);
        tick(1);
        check("post_rst_ack_e2", {31'd0, ack},   1);
        check("post_rst_dout",   {16'd0, dout},  32'hC0DE);
        check("post_rst_xfers",  {24'd0, xfers}, 1);
        dready = 1'b1;
        req = 1'b0;
        wait_ack(1'b0, "post_rst_release");
        tick(1);

        // Depth 3
        din = 16'hA5C3; req3 = 1'b1;
        tick(3);
        check("d3_ack_e2", {31'd0, ack3}, 0);
        tick(1);
        check("d3_ack_e3",    {31'd0, ack3},    1);
        check("d3_dvalid_e3", {31'd0, dvalid3}, 1);
        check("d3_dout_e3",   {16'd0, dout3},   32'hA5C3);
        tick(1);
        check("d3_dvalid_e4", {31'd0, dvalid3}, 0);
        req3 = 1'b0;
        tick(3);
        check("d3_release_e2", {31'd0, ack3}, 1);
        tick(1);
        check("d3_release_e3", {31'd0, ack3},   0);
        check("d3_xfers",      {24'd0, xfers3}, 1);

        tick(2);
        check("sb_empty",       sb.size(), 0);
        check("sb_pops_pushes", n_popped,  n_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/synch_resp.md
# synch_resp

Responder end of the four-phase request/acknowledge handshake used to move a data word into the `clk` domain from a loadable holding register driven by an asynchronous sender. It synchronises the incoming `req` level and captures `din` into a one-entry output buffer with valid/ready hand-off to local logic. It returns `ack` as a registered level and counts completed transfers. It sits at the receiving side of every cross-domain register path in the design.

## Interface

- `WIDTH`, default 16: data word width.
- `SYNC_STAGES`, default 2: synchroniser depth on `req`; minimum 2.
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  1: asynchronous request level from the sender.
- `din`  in  WIDTH: sender data; stable from before `req` rises until the sender sees `ack` high.
- `ack`  out  1: registered acknowledge level back to the sender.
- `dout`  out  WIDTH: captured word.
- `dvalid`  out  1: `dout` holds an unconsumed word.
- `dready`  in  1: local consumer accepts `dout` when `dvalid & dready`.
- `xfers`  out  8: count of captured words; wraps 255→0.

## Operation

- `req` passes through `SYNC_STAGES` flops; the last stage is `req_s`.
- `din` is not synchronised. The handshake guarantees it is stable when it is sampled.
- `free` = `!dvalid | dready`.
- State machine, two states:
  - IDLE (`ack`=0): if `req_s` and `free`, then `dout`←`din`, `dvalid`←1, `ack`←1, `xfers`←`xfers`+1, next state HOLD. If `req_s` and not `free`, stay in IDLE with `ack` held 0; this is backpressure, and `din` is not sampled.
  - HOLD (`ack`=1): if `!req_s`, then `ack`←0 and next state IDLE. Otherwise stay in HOLD. A new capture is never taken in HOLD.
- Buffer:
  - `dvalid & dready` with no capture on the same edge: `dvalid`←0 and `dout` holds its value.
  - Consume and capture on the same edge: `dout` takes the new word and `dvalid` stays 1. No bubble, no loss.
- `dready` while `dvalid`=0 has no effect.

## Timing

- Reset values: state IDLE, `ack`=0, `dvalid`=0, `dout`=0, `xfers`=0, all synchroniser flops 0.
- Request to capture:
  - `req` rises with setup before edge 0.
  - `req_s`=1 after edge `SYNC_STAGES`−1.
  - Capture, `ack`=1 and `dvalid`=1 all occur at edge `SYNC_STAGES`. This is 2 edges at the default depth.
- Release: after `req` falls, `ack` falls `SYNC_STAGES` edges later by the same counting.
- Minimum receiver-side cycle between captures is 2·`SYNC_STAGES`+2 edges. This excludes sender-side synchronisation.
- `dvalid` rises on the capture edge. It falls on the first edge with `dready`=1 and no capture.
- Reset mid-handshake: `ack` and `dvalid` drop immediately and asynchronously, and the held word is lost. If `req` is still high after reset release, a new capture occurs. Resetting the sender together with this block is a system requirement.
- A `req` glitch shorter than `SYNC_STAGES` cycles that reaches `req_s` is treated as a genuine request.

## Structure

- Shared package `synch_pkg` holds:
  - the state type (IDLE, HOLD);
  - constant `SYNC_STAGES_MIN` = 2;
  - constant `XFER_W` = 8.
- Sub-module `synch_chain`: parameterised N-stage synchroniser with async active-high reset. It is reused by other cross-domain blocks.
- Elaboration assertion: `SYNC_STAGES` ≥ `SYNC_STAGES_MIN`.

## Test plan

- **Reset state:** assert `reset` mid-simulation with `req`=0 → `ack`=0, `dvalid`=0, `dout`=0, `xfers`=0 in the same cycle without a clock edge.
- **Single transfer:** `din`=16'hA5C3, raise `req`, `dready`=1 →
  - `dout`=A5C3, `dvalid`=1 and `ack`=1 at edge 2;
  - `dvalid`=0 at edge 3;
  - drop `req` → `ack`=0 two edges later;
  - `xfers`=1.
- **Backpressure:** `dready`=0 with the first word held, second `req` with `din`=16'h1234 →
  - `ack` stays 0 and `dout` stays the first word;
  - raise `dready` → same-edge capture of 1234, `dvalid` stays 1, `ack` rises.
- **Wrap:** perform 256 transfers → `xfers` returns to 0. No transfer is dropped, checked against a scoreboard.
- **Reset mid-handshake:** assert `reset` while in HOLD with `req` high →
  - `ack`=0 immediately;
  - after release, with `req` still high, a capture follows 2 edges later and `xfers`=1.
- **Depth 3:** rerun the single-transfer scenario with `SYNC_STAGES`=3 → capture and `ack` rise at edge 3.
